ring_osc_freq_meter: RTL and testbench

//   Measures the ring-oscillator output by counting its rising edges over a

---
 rtl/ring_osc_pkg.sv | 15 +
 rtl/osc_sync_edge.sv | 33 +++
 rtl/ring_osc_freq_meter.sv | 107 ++++++++++
 tb/tb_ring_osc_freq_meter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ring_osc_pkg.sv
// rtl/ring_osc_pkg.sv - shared FSM encoding and default widths for the ring-oscillator frequency meter
package ring_osc_pkg;

   localparam int CNT_W_DEF       = 16;
   localparam int GATE_W_DEF      = 16;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_GATE = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/osc_sync_edge.sv
// rtl/osc_sync_edge.sv - multi-flop synchroniser with rising-edge pulse output
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   async_in  signal asynchronous to clk
//   rise      one-cycle pulse on each synchronised rising edge
module osc_sync_edge
   import ring_osc_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= '0;
         sync_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], async_in};
         sync_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// rtl/ring_osc_freq_meter.sv - counts oscillator rising edges over a programmable gate window
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   osc_in       oscillator input, asynchronous to clk
//   start        measurement request, honoured only in IDLE
//   gate_cycles  gate window length in clk cycles
//   busy         high in ARM and GATE
//   done         one-cycle result-valid pulse
//   count        edges seen in the last window, held until the next done
//   overflow     last window saturated the counter
module ring_osc_freq_meter
   import ring_osc_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int GATE_W      = GATE_W_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              osc_in,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_cycles,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

   state_t            state, state_nxt;
   logic [GATE_W-1:0] timer, timer_nxt;
   logic [CNT_W-1:0]  work, work_nxt;
   logic              work_ovf, work_ovf_nxt;
   logic              rise;

   osc_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_in(osc_in),
      .rise    (rise)
   );

   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      work_nxt     = work;
      work_ovf_nxt = work_ovf;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt    = ST_ARM;
               timer_nxt    = gate_cycles;
               work_nxt     = '0;
               work_ovf_nxt = 1'b0;
            end
         end
         ST_ARM: begin
            state_nxt = (timer == '0) ? ST_DONE : ST_GATE;
         end
         ST_GATE: begin
            if (rise) begin
               // Saturate rather than wrap so a fast oscillator reads as full-scale.
               if (work == CNT_MAX) work_ovf_nxt = 1'b1;
               else                 work_nxt     = work + CNT_ONE;
            end
            timer_nxt = timer - GATE_ONE;
            if (timer == GATE_ONE) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         timer    <= '0;
         work     <= '0;
         work_ovf <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         work     <= work_nxt;
         work_ovf <= work_ovf_nxt;
         // Load on entry to DONE so the result is already visible while done is high,
         // including any edge counted in the final GATE cycle.
         if (state_nxt == ST_DONE) begin
            count    <= work_nxt;
            overflow <= work_ovf_nxt;
         end
      end
   end

   assign busy = (state == ST_ARM) || (state == ST_GATE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// tb/tb_ring_osc_freq_meter.sv - directed self-checking bench for ring_osc_freq_meter
module tb_ring_osc_freq_meter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        osc_in = 1'b0;
   logic        start = 1'b0;
   logic [15:0] gate_cycles = '0;
   logic        busy, done, overflow;
   logic [15:0] count;

   logic        start2 = 1'b0;
   logic [15:0] gate2 = '0;
   logic        busy2, done2, overflow2;
   logic [3:0]  count2;

   int tests = 0;
   int fails = 0;

   bit osc_en = 1'b0;
   int osc_half = 5;
   int osc_ph = 0;

   ring_osc_freq_meter dut (
      .clk(clk), .rst(rst), .osc_in(osc_in), .start(start),
      .gate_cycles(gate_cycles), .busy(busy), .done(done),
      .count(count), .overflow(overflow)
   );

   ring_osc_freq_meter #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .osc_in(osc_in), .start(start2),
      .gate_cycles(gate2), .busy(busy2), .done(done2),
      .count(count2), .overflow(overflow2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (osc_en) begin
         osc_ph = osc_ph + 1;
         if (osc_ph >= osc_half) begin
            osc_ph = 0;
            osc_in = ~osc_in;
         end
      end
   end

   // Returns cycles from the start cycle to the first done (-1 on timeout);
   // busy_arm is busy sampled in the cycle after start.
   task automatic measure(input bit sel, input logic [15:0] g, output int lat, output logic busy_arm);
      @(negedge clk);
      if (sel) begin start2 = 1'b1; gate2 = g; end
      else     begin start  = 1'b1; gate_cycles = g; end
      @(negedge clk);
      start = 1'b0; start2 = 1'b0;
      busy_arm = sel ? busy2 : busy;
      lat = 1;
      while (!(sel ? done2 : done) && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 2000) lat = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      osc_half = 1; osc_ph = 0; osc_en = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({busy, done, overflow} !== 3'b000 || count !== 16'd0) begin
         fails++;
         $display("FAIL reset_flags: busy=%b done=%b ovf=%b count=%0d, required all 0", busy, done, overflow, count);
      end
      rst = 1'b0;
      osc_en = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, done, overflow} !== 3'b000 || count !== 16'd0) begin
         fails++;
         $display("FAIL reset_release: busy=%b done=%b ovf=%b count=%0d, required all 0", busy, done, overflow, count);
      end
   endtask

   task automatic test_basic;
      int lat; logic ba;
      osc_half = 5; osc_ph = 0; osc_en = 1'b1;
      measure(1'b0, 16'd100, lat, ba);
      tests++;
      if (ba !== 1'b1) begin fails++; $display("FAIL basic_busy_arm: got %b, required 1", ba); end
      tests++;
      if (lat !== 102) begin fails++; $display("FAIL basic_latency: got %0d, required 102", lat); end
      tests++;
      if (count !== 16'd10 || overflow !== 1'b0) begin
         fails++; $display("FAIL basic_count: count=%0d ovf=%b, required 10/0", count, overflow);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== 16'd10) begin
         fails++; $display("FAIL basic_after_done: done=%b busy=%b count=%0d, required 0/0/10", done, busy, count);
      end
   endtask

   task automatic test_overflow;
      int lat; logic ba;
      osc_half = 2; osc_ph = 0; osc_en = 1'b1;
      measure(1'b1, 16'd100, lat, ba);
      tests++;
      if (lat !== 102) begin fails++; $display("FAIL ovf_latency: got %0d, required 102", lat); end
      tests++;
      if (count2 !== 4'd15 || overflow2 !== 1'b1) begin
         fails++; $display("FAIL ovf_count: count=%0d ovf=%b, required 15/1", count2, overflow2);
      end
   endtask

   task automatic test_gate_zero;
      int lat; logic ba;
      osc_half = 5; osc_ph = 0; osc_en = 1'b1;
      measure(1'b0, 16'd0, lat, ba);
      tests++;
      if (lat !== 2) begin fails++; $display("FAIL gate0_latency: got %0d, required 2", lat); end
      tests++;
      if (count !== 16'd0 || overflow !== 1'b0) begin
         fails++; $display("FAIL gate0_count: count=%0d ovf=%b, required 0/0", count, overflow);
      end
      osc_en = 1'b0;
      osc_in = 1'b1;
      repeat (4) @(negedge clk);
      measure(1'b0, 16'd50, lat, ba);
      tests++;
      if (lat !== 52 || count !== 16'd0) begin
         fails++; $display("FAIL static_osc: lat=%0d count=%0d, required 52/0", lat, count);
      end
   endtask

   task automatic test_back_to_back;
      int n; int ndone; int first; int lat; logic ba;
      osc_half = 5; osc_ph = 0; osc_en = 1'b1;
      @(negedge clk);
      start = 1'b1; gate_cycles = 16'd100;
      n = 0; ndone = 0; first = -1;
      repeat (160) begin
         @(negedge clk);
         n++;
         start = (n == 30);
         if (n == 40) gate_cycles = 16'd20;
         if (done) begin
            ndone++;
            if (first < 0) first = n;
         end
      end
      start = 1'b0;
      tests++;
      if (ndone !== 1 || first !== 102) begin
         fails++; $display("FAIL b2b_single_done: count of done=%0d first=%0d, required 1 at 102", ndone, first);
      end
      tests++;
      if (count !== 16'd10) begin fails++; $display("FAIL b2b_result: got %0d, required 10", count); end
      measure(1'b0, 16'd50, lat, ba);
      tests++;
      if (lat !== 52 || count !== 16'd5) begin
         fails++; $display("FAIL b2b_second: lat=%0d count=%0d, required 52/5", lat, count);
      end
   endtask

   task automatic test_abort;
      int ndone;
      osc_half = 5; osc_ph = 0; osc_en = 1'b1;
      @(negedge clk);
      start = 1'b1; gate_cycles = 16'd100;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b, required 1", busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if ({busy, done, overflow} !== 3'b000 || count !== 16'd0) begin
         fails++; $display("FAIL abort_outputs: busy=%b done=%b ovf=%b count=%0d, required all 0", busy, done, overflow, count);
      end
      ndone = 0;
      repeat (150) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      tests++;
      if (ndone !== 0) begin fails++; $display("FAIL abort_no_done: active cycles=%0d, required 0", ndone); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_gate_zero();
      test_back_to_back();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
